// File: rtl/cv32e41s_pkg.sv
// Shared constants and types for the xsecure LFSR: default taps and seed, the per-cycle
// controller operation, and the fields the LFSR exports into the xsecure control bundle.
package cv32e41s_pkg;

  localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h8000_0057;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h2AA5_5AA5;

  // Decoded per cycle, priority LOAD > RECOVER > STEP > IDLE
  typedef enum logic [1:0] {
    LfsrIdle    = 2'd0,
    LfsrStep    = 2'd1,
    LfsrLoad    = 2'd2,
    LfsrRecover = 2'd3
  } lfsr_op_e;

  typedef struct packed {
    logic [31:0] lfsr0;
    logic        cntrst;
  } xsecure_ctrl_t;

endpackage

// File: rtl/cv32e41s_lfsr_step.sv
// One Galois LFSR step: shift right, fold the tap mask in when the dropped bit is set.
module cv32e41s_lfsr_step #(
  parameter logic [31:0] POLY = 32'h8000_0057
) (
  input  logic [31:0] lfsr_i,
  output logic [31:0] lfsr_o
);

  assign lfsr_o = (lfsr_i >> 1) ^ (lfsr_i[0] ? POLY : 32'h0);

endmodule

// File: rtl/cv32e41s_xsecure_lfsr.sv
// Seedable LFSR for dummy/hint instruction randomisation, with lockup recovery to a
// fixed seed and a registered counter-reset request on every seed or cpuctrl write.
module cv32e41s_xsecure_lfsr
  import cv32e41s_pkg::*;
#(
  parameter logic [31:0] LFSR_POLY         = LFSR_POLY_DEFAULT,
  parameter logic [31:0] LFSR_DEFAULT_SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        shift_i,
  input  logic        seed_we_i,
  input  logic [31:0] seed_wdata_i,
  input  logic        cpuctrl_we_i,
  output logic [31:0] lfsr_o,
  output logic [31:0] seed_rdata_o,
  output logic        cntrst_o,
  output logic        lockup_o
);

  logic [31:0] r_lfsr;
  logic        r_cntrst;
  logic        r_lockup;

  logic [31:0] w_lfsr_step;
  logic [31:0] w_lfsr_d;
  logic        w_lockup_d;
  logic        w_seed_zero;
  lfsr_op_e    w_op;

  cv32e41s_lfsr_step #(
    .POLY (LFSR_POLY)
  ) u_step (
    .lfsr_i (r_lfsr),
    .lfsr_o (w_lfsr_step)
  );

  assign w_seed_zero = (seed_wdata_i == 32'h0);

  always_comb begin
    w_op = LfsrIdle;
    if (seed_we_i) begin
      w_op = LfsrLoad;
    end else if (r_lfsr == 32'h0) begin
      w_op = LfsrRecover;
    end else if (shift_i && enable_i) begin
      w_op = LfsrStep;
    end
  end

  always_comb begin
    w_lfsr_d   = r_lfsr;
    w_lockup_d = 1'b0;
    unique case (w_op)
      LfsrLoad: begin
        // A zero seed would lock the LFSR, so it is replaced and flagged
        w_lfsr_d   = w_seed_zero ? LFSR_DEFAULT_SEED : seed_wdata_i;
        w_lockup_d = w_seed_zero;
      end
      LfsrRecover: begin
        w_lfsr_d   = LFSR_DEFAULT_SEED;
        w_lockup_d = 1'b1;
      end
      LfsrStep: w_lfsr_d = w_lfsr_step;
      LfsrIdle: w_lfsr_d = r_lfsr;
      default:  w_lfsr_d = r_lfsr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr   <= LFSR_DEFAULT_SEED;
      r_cntrst <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_lfsr   <= w_lfsr_d;
      r_cntrst <= seed_we_i | cpuctrl_we_i;
      r_lockup <= w_lockup_d;
    end
  end

  assign lfsr_o       = r_lfsr;
  assign seed_rdata_o = r_lfsr;
  assign cntrst_o     = r_cntrst;
  assign lockup_o     = r_lockup;

endmodule

// File: doc/cv32e41s_xsecure_lfsr.md
CV32E41S_XSECURE_LFSR -- requirements
Module: cv32e41s_xsecure_lfsr

Interface
REQ-001 Parameter LFSR_POLY, default 32'h8000_0057: Galois feedback tap mask.
REQ-002 Parameter LFSR_DEFAULT_SEED, default 32'h2AA5_5AA5: reset value and lockup-recovery value.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: asynchronous active-high reset.
REQ-005 Port enable_i, input, 1: LFSR allowed to advance (driven by cpuctrl.rnddummy).
REQ-006 Port shift_i, input, 1: one-cycle request to advance the LFSR by one step (a dummy or hint instruction leaves ID).
REQ-007 Port seed_we_i, input, 1: CSR write strobe for the seed register.
REQ-008 Port seed_wdata_i, input, 32: CSR write data for the seed.
REQ-009 Port cpuctrl_we_i, input, 1: CSR write strobe for cpuctrl.
REQ-010 Port lfsr_o, output, 32: current LFSR state; feeds xsecure_ctrl.lfsr0.
REQ-011 Port seed_rdata_o, output, 32: CSR read value; equals lfsr_o.
REQ-012 Port cntrst_o, output, 1: registered counter-reset request to the dummy-instruction counter.
REQ-013 Port lockup_o, output, 1: one-cycle pulse marking lockup recovery.

Function
REQ-014 Next-state step shall be: state = (q >> 1) XOR (q[0] ? LFSR_POLY : 0); 32-bit, no width growth.
REQ-015 The state shall advance exactly one step in a cycle with shift_i && enable_i && !seed_we_i; otherwise it holds.
REQ-016 seed_we_i shall load seed_wdata_i into the state on the next edge, regardless of enable_i.
REQ-017 seed_we_i and shift_i in the same cycle: the write wins and the shift is dropped, not deferred.
REQ-018 A seed write of 32'h0 shall load LFSR_DEFAULT_SEED and assert lockup_o for the following cycle.
REQ-019 If the state is ever 0 without a write (fault), the next edge shall load LFSR_DEFAULT_SEED and pulse lockup_o; shift_i is ignored that cycle.
REQ-020 cntrst_o shall be 1 exactly in the cycle after any cycle with seed_we_i or cpuctrl_we_i, and 0 otherwise.
REQ-021 Back-to-back writes shall hold cntrst_o high for consecutive cycles, with no pulse merging loss.
REQ-022 lfsr_o shall be combinationally driven from the register only; it has no path from shift_i or seed inputs.
REQ-023 Controller FSM states: IDLE (hold), STEP (advance), LOAD (seed write), RECOVER (zero detected); state is decoded per cycle with priority LOAD > RECOVER > STEP > IDLE.

Reset
REQ-024 On rst: lfsr_o = LFSR_DEFAULT_SEED, cntrst_o = 0, lockup_o = 0.
REQ-025 Reset asserted mid-operation shall abort a pending write or shift with no residual cntrst_o or lockup_o after release.
REQ-026 The first edge after rst deassertion shall act normally on the inputs sampled in that cycle.

Structure
REQ-027 LFSR_POLY and LFSR_DEFAULT_SEED defaults and the lfsr_lockup/step enum shall live in cv32e41s_pkg.
REQ-028 The step function shall be a pure combinational sub-module cv32e41s_lfsr_step (32-bit in, 32-bit out, POLY parameter).
REQ-029 The block shall be instantiated inside the xsecure control logic, with its outputs mapped to xsecure_ctrl_t.lfsr0 and cntrst.

Verification
REQ-030 Reset release, no inputs -> lfsr_o = 32'h2AA5_5AA5; cntrst_o = 0; lockup_o = 0 for 10 cycles.
REQ-031 Seed write 32'h0000_0001, then shift_i with enable_i=1 -> lfsr_o = 32'h0000_0001, then 32'h8000_0057; cntrst_o high exactly 1 cycle after the write.
REQ-032 Seed write 32'h0000_0002 with shift_i in the same cycle -> lfsr_o = 32'h0000_0002 (shift dropped); next shift -> 32'h0000_0001.
REQ-033 Seed write 32'h0 -> lfsr_o = 32'h2AA5_5AA5, lockup_o pulses 1 cycle, cntrst_o pulses 1 cycle.
REQ-034 enable_i=0 with shift_i held high for 5 cycles -> lfsr_o unchanged; cpuctrl_we_i pulse -> cntrst_o pulse.
REQ-035 rst asserted in the same cycle as seed_we_i -> after release lfsr_o = default seed and cntrst_o = 0.
